// File: rtl/ysyx_210544_mem_stage.sv
// Memory stage: takes one instruction from execute, runs at most one data-bus access,
// aligns load data, and then holds the result for writeback until it is acknowledged.
module ysyx_210544_mem_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_mem_executed_req,
  output logic        o_mem_executed_ack,
  output logic        o_mem_memoryed_req,
  input  logic        i_mem_memoryed_ack,
  input  logic [63:0] i_mem_pc,
  input  logic [31:0] i_mem_inst,
  input  logic [4:0]  i_mem_rd,
  input  logic        i_mem_rd_wen,
  input  logic [63:0] i_mem_rd_wdata,
  input  logic        i_mem_skipcmt,
  input  logic [31:0] i_mem_intrNo,
  input  logic        i_mem_ren,
  input  logic        i_mem_wen,
  input  logic [1:0]  i_mem_size,
  input  logic        i_mem_unsigned,
  input  logic [63:0] i_mem_addr,
  input  logic [63:0] i_mem_wdata,
  output logic        o_mem_bus_req,
  output logic        o_mem_bus_we,
  output logic [63:0] o_mem_bus_addr,
  output logic [63:0] o_mem_bus_wdata,
  output logic [7:0]  o_mem_bus_wstrb,
  input  logic        i_mem_bus_ack,
  input  logic [63:0] i_mem_bus_rdata,
  output logic [63:0] o_mem_pc,
  output logic [31:0] o_mem_inst,
  output logic [4:0]  o_mem_rd,
  output logic        o_mem_rd_wen,
  output logic [63:0] o_mem_rd_wdata,
  output logic        o_mem_skipcmt,
  output logic [31:0] o_mem_intrNo,
  output logic        o_mem_misaligned
);

  typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;

  state_t      state, state_next;
  logic [63:0] pc_r, rd_wdata_r, addr_r, wdata_r;
  logic [31:0] inst_r, intr_no_r;
  logic [4:0]  rd_r;
  logic        rd_wen_r, skipcmt_r, ren_r, wen_r, unsigned_r, mis_r;
  logic [1:0]  size_r;
  logic        aligned, is_access, take;
  logic [63:0] load_shift, load_data;
  logic [7:0]  strb_base;

  assign take      = (state == IDLE) && i_mem_executed_req;
  assign is_access = i_mem_ren | i_mem_wen;

  always_comb begin
    unique case (i_mem_size)
      2'd0:    aligned = 1'b1;
      2'd1:    aligned = ~i_mem_addr[0];
      2'd2:    aligned = (i_mem_addr[1:0] == 2'b00);
      default: aligned = (i_mem_addr[2:0] == 3'b000);
    endcase
  end

  always_comb begin
    load_shift = i_mem_bus_rdata >> {addr_r[2:0], 3'b000};
    unique case (size_r)
      2'd0:    load_data = unsigned_r ? {56'd0, load_shift[7:0]}  : {{56{load_shift[7]}},  load_shift[7:0]};
      2'd1:    load_data = unsigned_r ? {48'd0, load_shift[15:0]} : {{48{load_shift[15]}}, load_shift[15:0]};
      2'd2:    load_data = unsigned_r ? {32'd0, load_shift[31:0]} : {{32{load_shift[31]}}, load_shift[31:0]};
      default: load_data = load_shift;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (i_mem_executed_req) state_next = (is_access && aligned) ? BUS : DONE;
      BUS:  if (i_mem_bus_ack)      state_next = DONE;
      DONE: if (i_mem_memoryed_ack) state_next = IDLE;
      default:                      state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_r       <= '0;
      inst_r     <= '0;
      rd_r       <= '0;
      rd_wen_r   <= 1'b0;
      rd_wdata_r <= '0;
      skipcmt_r  <= 1'b0;
      intr_no_r  <= '0;
      ren_r      <= 1'b0;
      wen_r      <= 1'b0;
      size_r     <= '0;
      unsigned_r <= 1'b0;
      addr_r     <= '0;
      wdata_r    <= '0;
      mis_r      <= 1'b0;
    end else if (take) begin
      pc_r       <= i_mem_pc;
      inst_r     <= i_mem_inst;
      rd_r       <= i_mem_rd;
      rd_wen_r   <= i_mem_rd_wen;
      rd_wdata_r <= i_mem_rd_wdata;
      skipcmt_r  <= i_mem_skipcmt;
      intr_no_r  <= i_mem_intrNo;
      ren_r      <= i_mem_ren;
      wen_r      <= i_mem_wen;
      size_r     <= i_mem_size;
      unsigned_r <= i_mem_unsigned;
      addr_r     <= i_mem_addr;
      wdata_r    <= i_mem_wdata;
      mis_r      <= is_access & ~aligned;
    end else if (state == BUS && i_mem_bus_ack && ren_r && !wen_r) begin
      // Load result replaces the ALU value; stores keep the registered rd_wdata.
      rd_wdata_r <= load_data;
    end
  end

  always_comb begin
    unique case (size_r)
      2'd0:    strb_base = 8'h01;
      2'd1:    strb_base = 8'h03;
      2'd2:    strb_base = 8'h0F;
      default: strb_base = 8'hFF;
    endcase
  end

  always_comb begin
    o_mem_executed_ack = (state == IDLE);
    o_mem_memoryed_req = 1'b0;
    o_mem_bus_req      = 1'b0;
    o_mem_bus_we       = 1'b0;
    o_mem_bus_addr     = '0;
    o_mem_bus_wdata    = '0;
    o_mem_bus_wstrb    = '0;
    o_mem_pc           = '0;
    o_mem_inst         = '0;
    o_mem_rd           = '0;
    o_mem_rd_wen       = 1'b0;
    o_mem_rd_wdata     = '0;
    o_mem_skipcmt      = 1'b0;
    o_mem_intrNo       = '0;
    o_mem_misaligned   = 1'b0;
    if (state == BUS) begin
      o_mem_bus_req  = 1'b1;
      o_mem_bus_we   = wen_r;
      o_mem_bus_addr = {addr_r[63:3], 3'b000};
      if (wen_r) begin
        o_mem_bus_wdata = wdata_r << {addr_r[2:0], 3'b000};
        o_mem_bus_wstrb = strb_base << addr_r[2:0];
      end
    end
    if (state == DONE) begin
      o_mem_memoryed_req = 1'b1;
      o_mem_pc           = pc_r;
      o_mem_inst         = inst_r;
      o_mem_rd           = rd_r;
      o_mem_rd_wen       = rd_wen_r & ~mis_r;
      o_mem_rd_wdata     = rd_wdata_r;
      o_mem_skipcmt      = skipcmt_r;
      o_mem_intrNo       = intr_no_r;
      o_mem_misaligned   = mis_r;
    end
  end

endmodule

// File: doc/ysyx_210544_mem_stage.md
YSYX_210544_MEM_STAGE -- requirements
Module: ysyx_210544_mem_stage

Interface
REQ-001 SHALL use one clock; reset is asynchronous and active-low.
REQ-002 clk  in  1  stage clock, all state on rising edge.
REQ-003 rst  in  1  asynchronous active-low reset.
REQ-004 i_mem_executed_req in 1 / o_mem_executed_ack out 1  upstream (execute) handshake; transfer when both high at a rising edge.
REQ-005 o_mem_memoryed_req out 1 / i_mem_memoryed_ack in 1  downstream (writeback) handshake.
REQ-006 i_mem_pc in 64, i_mem_inst in 32, i_mem_rd in 5, i_mem_rd_wen in 1, i_mem_rd_wdata in 64 (ALU result), i_mem_skipcmt in 1, i_mem_intrNo in 32  pass-through instruction context.
REQ-007 i_mem_ren in 1, i_mem_wen in 1, i_mem_size in 2 (0=B,1=H,2=W,3=D), i_mem_unsigned in 1, i_mem_addr in 64, i_mem_wdata in 64  access descriptor.
REQ-008 o_mem_bus_req out 1, o_mem_bus_we out 1, o_mem_bus_addr out 64, o_mem_bus_wdata out 64, o_mem_bus_wstrb out 8, i_mem_bus_ack in 1, i_mem_bus_rdata in 64  data-memory bus; ack is a one-cycle pulse, rdata valid with ack.
REQ-009 o_mem_pc out 64, o_mem_inst out 32, o_mem_rd out 5, o_mem_rd_wen out 1, o_mem_rd_wdata out 64, o_mem_skipcmt out 1, o_mem_intrNo out 32, o_mem_misaligned out 1  results to writeback.

Function
REQ-010 FSM states IDLE, BUS, DONE; o_mem_executed_ack SHALL be high only in IDLE.
REQ-011 On upstream handshake, all i_mem_* inputs SHALL be registered; next state BUS if (ren|wen) and aligned, else DONE.
REQ-012 Alignment: H needs addr[0]=0, W needs addr[1:0]=0, D needs addr[2:0]=0, B always aligned; misaligned access SHALL skip BUS, set o_mem_misaligned=1, force o_mem_rd_wen=0 in DONE.
REQ-013 In BUS, o_mem_bus_req SHALL be 1 and addr/we/wdata/wstrb held constant until the cycle i_mem_bus_ack=1; next state DONE.
REQ-014 o_mem_bus_addr = {addr[63:3],3'b000}; o_mem_bus_we = wen (wen has priority if ren and wen both set).
REQ-015 Store: o_mem_bus_wdata = wdata << (8*addr[2:0]); o_mem_bus_wstrb = (0x01/0x03/0x0F/0xFF per size) << addr[2:0].
REQ-016 Load: shifted = rdata >> (8*addr[2:0]), truncated to size, sign-extended to 64 unless unsigned (D ignores unsigned); captured on ack cycle.
REQ-017 o_mem_rd_wdata SHALL be loaded data for aligned loads, else registered i_mem_rd_wdata.
REQ-018 In DONE o_mem_memoryed_req=1 and all o_mem_* result outputs show registered values; outside DONE all result outputs and o_mem_misaligned SHALL be 0.
REQ-019 DONE -> IDLE on edge with i_mem_memoryed_ack=1; req held otherwise.
REQ-020 Latency: non-memory op, memoryed_req high 1 cycle after upstream handshake; memory op, memoryed_req high 1 cycle after bus ack cycle.
REQ-021 Outside BUS, o_mem_bus_req=0 and bus addr/wdata/wstrb/we = 0.
REQ-022 i_mem_bus_ack outside BUS SHALL be ignored.

Reset
REQ-023 rst=0 SHALL immediately force IDLE and zero all registers and outputs except o_mem_executed_ack=1 (IDLE); mid-BUS reset abandons the access, outstanding ack after release is ignored.

Verification
REQ-024 Non-memory op pc=0x80000000, rd=5, rd_wdata=0x1234, WB ack tied 1 -> memoryed_req high next cycle, o_mem_rd_wdata=0x1234, then IDLE.
REQ-025 LB addr=0x1003, signed, bus rdata=0x00000000_80000000 after 3 wait cycles -> bus_addr=0x1000, req held 4 cycles, o_mem_rd_wdata=0xFFFF_FFFF_FFFF_FF80; LBU -> 0x80.
REQ-026 SH addr=0x2006, wdata=0xBEEF -> bus_we=1, wstrb=0xC0, wdata=0xBEEF_0000_0000_0000, rd_wen out=0 if input 0.
REQ-027 LW addr=0x3002 -> no bus_req, o_mem_misaligned=1, o_mem_rd_wen=0, memoryed_req next cycle.
REQ-028 WB ack held low 5 cycles in DONE -> outputs stable, executed_ack stays 0; rst pulsed during BUS -> all outputs 0 asynchronously, late bus ack ignored.
